// File: rtl/boron_job_arbiter.sv
// Round-robin job sequencer that shares one boron_enc core between NUM_REQ requesters.
// One job in flight: grant, start the core, wait for done or timeout, respond, then flush the core.
module boron_job_arbiter #(
   parameter int NUM_REQ      = 2,
   parameter int TIMEOUT      = 64,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [NUM_REQ*64-1:0] req_plain,
   input  logic [NUM_REQ*80-1:0] req_key,
   output logic [NUM_REQ-1:0]    resp_valid,
   input  logic [NUM_REQ-1:0]    resp_ready,
   output logic [63:0]           resp_data,
   output logic                  resp_err,
   output logic                  busy,
   output logic                  core_start,
   output logic                  core_rst,
   output logic [63:0]           core_plain,
   output logic [79:0]           core_key,
   input  logic                  core_done,
   input  logic [63:0]           core_cipher
);

   localparam int GW = $clog2(NUM_REQ);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int FW = $clog2(FLUSH_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_BUSY,
      S_RESP,
      S_FLUSH
   } state_t;

   state_t          state;
   logic [GW-1:0]   rr_ptr;
   logic [GW-1:0]   grant_q;
   logic [GW-1:0]   grant_idx;
   logic            grant_any;
   logic [TW-1:0]   tmo_cnt;
   logic [FW-1:0]   flush_cnt;

   logic [63:0]     plain_arr [NUM_REQ];
   logic [79:0]     key_arr   [NUM_REQ];

   function automatic logic [GW-1:0] wrap_idx(input int v);
      return GW'(v % NUM_REQ);
   endfunction

   function automatic logic [NUM_REQ-1:0] onehot(input logic [GW-1:0] i);
      return NUM_REQ'(1) << i;
   endfunction

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign plain_arr[i] = req_plain[64*i +: 64];
      assign key_arr[i]   = req_key[80*i +: 80];
   end

   // Scan downwards so the lane closest to rr_ptr is the last (winning) assignment.
   always_comb begin
      grant_idx = '0;
      grant_any = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req_valid[wrap_idx(int'(rr_ptr) + k)]) begin
            grant_idx = wrap_idx(int'(rr_ptr) + k);
            grant_any = 1'b1;
         end
      end
   end

   assign req_ready  = (state == S_IDLE && grant_any) ? onehot(grant_idx) : '0;
   assign resp_valid = (state == S_RESP) ? onehot(grant_q) : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_FLUSH;
         flush_cnt  <= '0;
         tmo_cnt    <= '0;
         rr_ptr     <= '0;
         grant_q    <= '0;
         busy       <= 1'b1;
         core_start <= 1'b0;
         core_rst   <= 1'b0;
         core_plain <= '0;
         core_key   <= '0;
         resp_data  <= '0;
         resp_err   <= 1'b0;
      end else begin
         core_start <= 1'b0;
         case (state)
            S_IDLE: begin
               if (grant_any) begin
                  core_plain <= plain_arr[grant_idx];
                  core_key   <= key_arr[grant_idx];
                  grant_q    <= grant_idx;
                  core_start <= 1'b1;
                  busy       <= 1'b1;
                  state      <= S_START;
               end
            end
            S_START: begin
               tmo_cnt <= '0;
               state   <= S_BUSY;
            end
            // A done seen on the timeout cycle still counts as a good result.
            S_BUSY: begin
               if (core_done) begin
                  resp_data <= core_cipher;
                  resp_err  <= 1'b0;
                  state     <= S_RESP;
               end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                  resp_data <= '0;
                  resp_err  <= 1'b1;
                  state     <= S_RESP;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end
            S_RESP: begin
               if (resp_ready[grant_q]) begin
                  rr_ptr    <= wrap_idx(int'(grant_q) + 1);
                  flush_cnt <= '0;
                  core_rst  <= 1'b0;
                  state     <= S_FLUSH;
               end
            end
            S_FLUSH: begin
               if (flush_cnt == FW'(FLUSH_CYCLES - 1)) begin
                  core_rst <= 1'b1;
                  busy     <= 1'b0;
                  state    <= S_IDLE;
               end else begin
                  flush_cnt <= flush_cnt + FW'(1);
               end
            end
            default: state <= S_FLUSH;
         endcase
      end
   end

endmodule
